lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 146 ++++++++++++++
 tb/tb_lfsr_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Serial LFSR sequence checker: Galois reference register, lock/loss FSM and error counting.
// Optional LFSR_CHK_BITCNT_EN adds a saturating count of beats compared while locked.
module lfsr_checker #(
  parameter int unsigned N        = 26,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             load,
  input  logic [3:0]       s,
  input  logic             din_valid,
  input  logic             din,
  output logic [1:0]       state,
  output logic             locked,
  output logic             err,
`ifdef LFSR_CHK_BITCNT_EN
  output logic [31:0]      bit_cnt,
`endif
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned LockW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LossW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StArmed  = 2'b01,
    StLocked = 2'b10,
    StLost   = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       ref_q, ref_d, ref_next;
  logic [LockW-1:0]   match_run_q, match_run_d;
  logic [LossW-1:0]   miss_run_q, miss_run_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
`ifdef LFSR_CHK_BITCNT_EN
  logic [31:0]        bit_cnt_q, bit_cnt_d;
`endif
  logic               accept, match;

  // Galois advance: the outgoing MSB feeds bit 0 and is folded into taps 1, 2 and 6.
  always_comb begin
    ref_next    = '0;
    ref_next[0] = ref_q[N-1];
    for (int i = 1; i < N; i++) begin
      if (i == 1 || i == 2 || i == 6) begin
        ref_next[i] = ref_q[i-1] ^ ref_q[N-1];
      end else begin
        ref_next[i] = ref_q[i-1];
      end
    end
  end

  assign accept = din_valid && (state_q == StArmed || state_q == StLocked);
  assign match  = (din == ref_q[N-1]);

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
`ifdef LFSR_CHK_BITCNT_EN
    bit_cnt_d   = bit_cnt_q;
`endif
    if (load) begin
      // Load wins over a coincident beat, which is dropped without advancing ref.
      state_d     = StArmed;
      ref_d       = {{(N-4){1'b0}}, s};
      match_run_d = '0;
      miss_run_d  = '0;
      err_cnt_d   = '0;
`ifdef LFSR_CHK_BITCNT_EN
      bit_cnt_d   = '0;
`endif
    end else if (accept) begin
      ref_d = ref_next;
      unique case (state_q)
        StArmed: begin
          if (match) begin
            match_run_d = match_run_q + LockW'(1);
            if (match_run_q == LockW'(LOCK_CNT - 1)) begin
              state_d    = StLocked;
              miss_run_d = '0;
            end
          end else begin
            match_run_d = '0;
            err_d       = 1'b1;
          end
        end
        StLocked: begin
`ifdef LFSR_CHK_BITCNT_EN
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 32'd1;
`endif
          if (match) begin
            miss_run_d = '0;
          end else begin
            err_d      = 1'b1;
            miss_run_d = miss_run_q + LossW'(1);
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (miss_run_q == LossW'(LOSS_CNT - 1)) state_d = StLost;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_q     <= StIdle;
      ref_q       <= '0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
`ifdef LFSR_CHK_BITCNT_EN
      bit_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
`ifdef LFSR_CHK_BITCNT_EN
      bit_cnt_q   <= bit_cnt_d;
`endif
    end
  end

  assign state   = state_q;
  assign locked  = (state_q == StLocked);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`ifdef LFSR_CHK_BITCNT_EN
  assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: vector table, directed corner sequences and a randomized run
// against a polynomial-arithmetic reference model.
module tb_lfsr_checker;

  localparam int unsigned N       = 26;
  localparam int unsigned LOCK    = 8;
  localparam int unsigned LOSS    = 4;
  localparam int unsigned ERR_W   = 5;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;
  // x^26 feedback folded into bits 0, 1, 2 and 6
  localparam logic [N-1:0] POLY   = 26'h47;

  logic             clk = 1'b0;
  logic             r_n = 1'b1;
  logic             load = 1'b0;
  logic [3:0]       s = 4'd0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic [1:0]       state;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
`ifdef LFSR_CHK_BITCNT_EN
  logic [31:0]      bit_cnt;
`endif

  lfsr_checker #(
    .N       (N),
    .LOCK_CNT(LOCK),
    .LOSS_CNT(LOSS),
    .ERR_W   (ERR_W)
  ) dut (
    .clk      (clk),
    .r_n      (r_n),
    .load     (load),
    .s        (s),
    .din_valid(din_valid),
    .din      (din),
    .state    (state),
    .locked   (locked),
    .err      (err),
`ifdef LFSR_CHK_BITCNT_EN
    .bit_cnt  (bit_cnt),
`endif
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [N-1:0] m_ref;
  int           m_st, m_run, m_miss, m_cnt;
  logic         m_err;
  longint       m_bit;

  typedef struct {
    logic       ld;
    logic [3:0] sd;
    logic       dv;
    logic       d;
    int         st;
    logic       e;
    int         cnt;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ref = '0; m_st = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_err = 1'b0; m_bit = 0;
  endtask

  function automatic logic model_exp();
    return m_ref[N-1];
  endfunction

  task automatic model_step(input logic ld, input logic [3:0] sd, input logic dv, input logic d);
    logic e;
    m_err = 1'b0;
    if (ld) begin
      m_ref = N'(sd); m_st = 1; m_run = 0; m_miss = 0; m_cnt = 0; m_bit = 0;
    end else if (dv && (m_st == 1 || m_st == 2)) begin
      e = m_ref[N-1];
      m_ref = (m_ref << 1) ^ (e ? POLY : '0);
      if (m_st == 1) begin
        if (d == e) begin
          m_run++;
          if (m_run == LOCK) begin m_st = 2; m_miss = 0; end
        end else begin
          m_run = 0; m_err = 1'b1;
        end
      end else begin
        if (m_bit < 64'hFFFF_FFFF) m_bit++;
        if (d != e) begin
          m_err = 1'b1;
          if (m_cnt < ERR_MAX) m_cnt++;
          m_miss++;
          if (m_miss == LOSS) m_st = 3;
        end else begin
          m_miss = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, state, m_st);
    chk({tag, ".locked"}, locked, (m_st == 2));
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".err_cnt"}, err_cnt, m_cnt);
`ifdef LFSR_CHK_BITCNT_EN
    chk({tag, ".bit_cnt"}, bit_cnt, m_bit);
`endif
  endtask

  task automatic cyc(input string tag, input logic ld, input logic [3:0] sd, input logic dv,
                     input logic d);
    load = ld; s = sd; din_valid = dv; din = d;
    @(posedge clk);
    model_step(ld, sd, dv, d);
    #1;
    check_all(tag);
  endtask

  task automatic push(input logic ld, input logic [3:0] sd, input logic dv, input logic d,
                      input int st, input logic e, input int cnt);
    vec_t v;
    v.ld = ld; v.sd = sd; v.dv = dv; v.d = d; v.st = st; v.e = e; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic lock_seq(input logic [3:0] sd);
    cyc("lock.load", 1'b1, sd, 1'b0, 1'b0);
    for (int i = 0; i < int'(LOCK); i++) cyc("lock.beat", 1'b0, 4'd0, 1'b1, model_exp());
    chk("lock.state", state, 2);
  endtask

  initial begin
    model_reset();
    // Asynchronous reset between edges
    #2 r_n = 1'b0;
    #1;
    chk("rst.state", state, 0);
    chk("rst.locked", locked, 0);
    chk("rst.err", err, 0);
    chk("rst.err_cnt", err_cnt, 0);
    #9 r_n = 1'b1;

    // Vector table: IDLE ignores beats; seed 1 locks after 8 zeros, bit 26 is the first 1
    for (int i = 0; i < 3; i++) push(1'b0, 4'd0, 1'b1, 1'b1, 0, 1'b0, 0);
    push(1'b1, 4'd1, 1'b0, 1'b0, 1, 1'b0, 0);
    for (int b = 1; b <= 25; b++) push(1'b0, 4'd0, 1'b1, 1'b0, (b >= 8) ? 2 : 1, 1'b0, 0);
    push(1'b0, 4'd0, 1'b1, 1'b1, 2, 1'b0, 0);
    // Same stream but beat 26 forced to 0: one error while locked
    push(1'b1, 4'd1, 1'b0, 1'b0, 1, 1'b0, 0);
    for (int b = 1; b <= 25; b++) push(1'b0, 4'd0, 1'b1, 1'b0, (b >= 8) ? 2 : 1, 1'b0, 0);
    push(1'b0, 4'd0, 1'b1, 1'b0, 2, 1'b1, 1);
    push(1'b0, 4'd0, 1'b0, 1'b0, 2, 1'b0, 1);
    // Load with a coincident beat while locked: beat dropped, seed 2 puts the first 1 at beat 25
    push(1'b1, 4'd2, 1'b1, 1'b1, 1, 1'b0, 0);
    for (int b = 1; b <= 24; b++) push(1'b0, 4'd0, 1'b1, 1'b0, (b >= 8) ? 2 : 1, 1'b0, 0);
    push(1'b0, 4'd0, 1'b1, 1'b1, 2, 1'b0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cyc("tbl", vq[i].ld, vq[i].sd, vq[i].dv, vq[i].d);
      chk("tbl.state", state, vq[i].st);
      chk("tbl.err", err, vq[i].e);
      chk("tbl.err_cnt", err_cnt, vq[i].cnt);
    end

    // Loss of lock after consecutive misses, then frozen
    lock_seq(4'd9);
    for (int i = 0; i < int'(LOSS); i++) begin
      cyc("loss.miss", 1'b0, 4'd0, 1'b1, ~model_exp());
      chk("loss.err", err, 1);
    end
    chk("loss.state", state, 3);
    chk("loss.err_cnt", err_cnt, 4);
    for (int i = 0; i < 5; i++) cyc("lost.hold", 1'b0, 4'd0, 1'b1, 1'($urandom_range(1)));
    chk("lost.state", state, 3);
    chk("lost.err_cnt", err_cnt, 4);

    // Error counter saturation with alternating miss/match
    lock_seq(4'd7);
    for (int i = 0; i < 40; i++) begin
      cyc("sat.miss", 1'b0, 4'd0, 1'b1, ~model_exp());
      cyc("sat.match", 1'b0, 4'd0, 1'b1, model_exp());
    end
    chk("sat.err_cnt", err_cnt, ERR_MAX);
    chk("sat.state", state, 2);

    // Zero seed gives an all-zero sequence
    lock_seq(4'd0);
    cyc("zero.one", 1'b0, 4'd0, 1'b1, 1'b1);
    chk("zero.err", err, 1);
    for (int i = 0; i < 30; i++) cyc("zero.z", 1'b0, 4'd0, 1'b1, 1'b0);

`ifdef LFSR_CHK_BITCNT_EN
    lock_seq(4'd3);
    for (int i = 0; i < 100; i++) cyc("bc.beat", 1'b0, 4'd0, 1'b1, model_exp());
    chk("bc.bit_cnt", bit_cnt, 100);
`endif

    // Reset mid-stream right after a mismatch, then beats alone cannot leave IDLE
    lock_seq(4'd5);
    cyc("mrst.miss", 1'b0, 4'd0, 1'b1, ~model_exp());
    load = 1'b0; din_valid = 1'b0;
    #2 r_n = 1'b0;
    model_reset();
    #1;
    chk("mrst.state", state, 0);
    chk("mrst.locked", locked, 0);
    chk("mrst.err", err, 0);
    chk("mrst.err_cnt", err_cnt, 0);
    #2 r_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc("mrst.idle", 1'b0, 4'd0, 1'b1, 1'($urandom_range(1)));
    chk("mrst.stay_idle", state, 0);

    // Randomized traffic with gaps, occasional reloads and injected errors
    for (int i = 0; i < 3000; i++) begin
      logic       ld, dv, d;
      logic [3:0] sd;
      ld = ($urandom_range(59) == 0);
      sd = 4'($urandom_range(15));
      dv = ($urandom_range(9) < 7);
      d  = ($urandom_range(11) != 0) ? model_exp() : 1'($urandom_range(1));
      if (m_st == 0 && i > 3) ld = 1'b1;
      cyc("rnd", ld, sd, dv, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
